// File: rtl/matrix_frame_loader.sv
// Writer side of the operand RAM: packs a host byte frame (size, 32 A bytes, 32 B bytes)
// into three words at BASE_ADDR+0/+1/+2, then pulses o_done.
module matrix_frame_loader #(
    parameter int DATA_W      = 256,
    parameter int ADDR_W      = 8,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_size_out
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(BYTES);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WR_HDR,
        S_COL_A,
        S_WR_A,
        S_COL_B,
        S_WR_B,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_buf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [2:0]         r_size;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_wdata;

    logic               w_transfer;
    logic               w_collect;
    logic               w_timeout;
    logic               w_hdr_ok;
    logic               w_last_byte;
    logic [DATA_W-1:0]  w_buf_next;

    assign w_transfer  = i_s_valid & o_s_ready;
    assign w_collect   = (r_state == S_HDR) || (r_state == S_COL_A) || (r_state == S_COL_B);
    assign w_timeout   = w_collect && !w_transfer && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_hdr_ok    = (i_s_data >= 8'd2) && (i_s_data <= 8'd5);
    assign w_last_byte = (r_idx == IDX_W'(BYTES - 1));

    // First accepted byte of a word lands in the least significant lane.
    always_comb begin
        w_buf_next                           = r_buf;
        w_buf_next[{r_idx, 3'b000} +: 8]     = i_s_data;
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path leaves w_state_next unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_next = S_HDR;
            S_HDR: begin
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                end else if (w_transfer) begin
                    w_state_next = w_hdr_ok ? S_WR_HDR : S_IDLE;
                end
            end
            S_WR_HDR: w_state_next = S_COL_A;
            S_COL_A: begin
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                end else if (w_transfer && w_last_byte) begin
                    w_state_next = S_WR_A;
                end
            end
            S_WR_A:   w_state_next = S_COL_B;
            S_COL_B: begin
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                end else if (w_transfer && w_last_byte) begin
                    w_state_next = S_WR_B;
                end
            end
            S_WR_B:   w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_s_ready = 1'b0;
        o_ram_we  = 1'b0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        case (r_state)
            S_IDLE:                   o_busy    = 1'b0;
            S_HDR, S_COL_A, S_COL_B:  o_s_ready = 1'b1;
            S_WR_HDR, S_WR_A, S_WR_B: o_ram_we  = 1'b1;
            S_DONE:                   o_done    = 1'b1;
            default:                  o_busy    = 1'b0;
        endcase
    end

    assign o_err       = r_err;
    assign o_size_out  = r_size;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;

    // Idle-cycle counter: cleared on every transfer and whenever not collecting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_collect && !w_transfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Error flag and latched header size
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_size <= 3'd0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_err <= 1'b0;
            end else if (w_timeout || (r_state == S_HDR && w_transfer && !w_hdr_ok)) begin
                r_err <= 1'b1;
            end
            if (r_state == S_HDR && w_transfer && w_hdr_ok) begin
                r_size <= i_s_data[2:0];
            end
        end
    end

    // Pack buffer and byte index; a timed-out partial word is dropped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_buf <= '0;
        end else if ((r_state == S_IDLE && i_start) || w_timeout) begin
            r_idx <= '0;
            r_buf <= '0;
        end else if ((r_state == S_COL_A || r_state == S_COL_B) && w_transfer) begin
            r_idx <= w_last_byte ? '0 : r_idx + IDX_W'(1);
            r_buf <= w_last_byte ? '0 : w_buf_next;
        end
    end

    // Write port registers load on the completing transfer so they are valid throughout the we cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_transfer && !w_timeout) begin
            if (r_state == S_HDR && w_hdr_ok) begin
                r_ram_addr  <= ADDR_W'(BASE_ADDR);
                r_ram_wdata <= {{(DATA_W - 8){1'b0}}, i_s_data};
            end else if (r_state == S_COL_A && w_last_byte) begin
                r_ram_addr  <= ADDR_W'(BASE_ADDR + 1);
                r_ram_wdata <= w_buf_next;
            end else if (r_state == S_COL_B && w_last_byte) begin
                r_ram_addr  <= ADDR_W'(BASE_ADDR + 2);
                r_ram_wdata <= w_buf_next;
            end
        end
    end

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Self-checking bench for matrix_frame_loader: header table, full frames with random gaps,
// timeout, mid-frame reset and start-while-busy sequences.
module tb_matrix_frame_loader;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [7:0]        i_s_data = 8'd0;
    logic              i_s_valid = 1'b0;
    logic              o_s_ready;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic              o_ram_we;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [2:0]        o_size_out;

    matrix_frame_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(0), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_s_data(i_s_data), .i_s_valid(i_s_valid),
        .o_s_ready(o_s_ready), .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
        .o_ram_we(o_ram_we), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_size_out(o_size_out)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Write monitor: records every RAM write and checks port-level rules.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t wq[$];
    int  done_cnt = 0;
    bit  prev_we  = 1'b0;

    always @(negedge clk) begin
        if (o_ram_we) begin
            wq.push_back('{o_ram_addr, o_ram_wdata});
            check("ready_during_we", DATA_W'(o_s_ready), '0);
            check("we_back_to_back", DATA_W'(prev_we), '0);
        end
        if (o_done) done_cnt++;
        prev_we = o_ram_we;
    end

    // Reference frame contents and word packing (byte k -> bits 8k+7:8k).
    logic [7:0] fa[32];
    logic [7:0] fb[32];

    function automatic logic [DATA_W-1:0] pack(input bit sel_b);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) w[8*k +: 8] = sel_b ? fb[k] : fa[k];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int guard;
        repeat (gap) tick();
        i_s_valid = 1'b1;
        i_s_data  = b;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = o_s_ready;
            tick();
            guard++;
        end
        if (!acc) fail_now("byte_accept_timeout");
        i_s_valid = 1'b0;
    endtask

    // Start pulse with the header already offered: it must not be taken in IDLE.
    task automatic start_hdr(input logic [7:0] hdr);
        i_start   = 1'b1;
        i_s_valid = 1'b1;
        i_s_data  = hdr;
        @(negedge clk);
        check("ready_in_idle", DATA_W'(o_s_ready), '0);
        check("busy_in_idle", DATA_W'(o_busy), '0);
        tick();
        i_start = 1'b0;
        check("err_cleared_by_start", DATA_W'(o_err), '0);
        send_byte(hdr, 0);
    endtask

    task automatic randomize_frame();
        for (int k = 0; k < 32; k++) begin
            fa[k] = 8'($urandom);
            fb[k] = 8'($urandom);
        end
    endtask

    task automatic run_frame(input logic [7:0] hdr, input int gap_max, input bit start_mid);
        int d0;
        int guard;
        wq.delete();
        d0 = done_cnt;
        start_hdr(hdr);
        for (int k = 0; k < 32; k++) begin
            send_byte(fa[k], $urandom_range(gap_max, 0));
            if (start_mid && k == 4) begin
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
            end
        end
        for (int k = 0; k < 32; k++) send_byte(fb[k], $urandom_range(gap_max, 0));
        guard = 0;
        while (done_cnt == d0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt == d0) fail_now("done_timeout");
        repeat (3) tick();
        check("done_pulses", DATA_W'(done_cnt - d0), DATA_W'(1));
        check("busy_after_done", DATA_W'(o_busy), '0);
        check("err_after_frame", DATA_W'(o_err), '0);
        check("size_out", DATA_W'(o_size_out), DATA_W'(hdr[2:0]));
        check("n_writes", DATA_W'(wq.size()), DATA_W'(3));
        if (wq.size() >= 3) begin
            check("addr_hdr", DATA_W'(wq[0].addr), DATA_W'(0));
            check("data_hdr", wq[0].data, DATA_W'(hdr));
            check("addr_a", DATA_W'(wq[1].addr), DATA_W'(1));
            check("data_a", wq[1].data, pack(1'b0));
            check("addr_b", DATA_W'(wq[2].addr), DATA_W'(2));
            check("data_b", wq[2].data, pack(1'b1));
        end
    endtask

    typedef struct {
        logic [7:0] hdr;
        bit         exp_err;
        logic [2:0] exp_size;
    } hdr_vec_t;

    hdr_vec_t vecs[9];

    initial begin
        vecs[0] = '{8'h03, 1'b0, 3'd3};
        vecs[1] = '{8'h07, 1'b1, 3'd3};
        vecs[2] = '{8'h01, 1'b1, 3'd3};
        vecs[3] = '{8'h02, 1'b0, 3'd2};
        vecs[4] = '{8'h00, 1'b1, 3'd2};
        vecs[5] = '{8'h05, 1'b0, 3'd5};
        vecs[6] = '{8'h04, 1'b0, 3'd4};
        vecs[7] = '{8'h82, 1'b1, 3'd4};
        vecs[8] = '{8'h06, 1'b1, 3'd4};

        repeat (3) tick();
        check("rst_we", DATA_W'(o_ram_we), '0);
        check("rst_busy", DATA_W'(o_busy), '0);
        check("rst_done", DATA_W'(o_done), '0);
        check("rst_err", DATA_W'(o_err), '0);
        check("rst_ready", DATA_W'(o_s_ready), '0);
        check("rst_addr", DATA_W'(o_ram_addr), '0);
        check("rst_wdata", o_ram_wdata, '0);
        check("rst_size", DATA_W'(o_size_out), '0);
        rst = 1'b0;
        tick();

        // Known frame: A = 0x01..0x20, B = 0x21..0x40, back to back.
        for (int k = 0; k < 32; k++) begin
            fa[k] = 8'(k + 1);
            fb[k] = 8'(k + 33);
        end
        run_frame(8'h03, 0, 1'b0);
        if (wq.size() >= 3) begin
            check("a_lsb", DATA_W'(wq[1].data[7:0]), DATA_W'(8'h01));
            check("a_msb", DATA_W'(wq[1].data[255:248]), DATA_W'(8'h20));
            check("b_lsb", DATA_W'(wq[2].data[7:0]), DATA_W'(8'h21));
            check("b_msb", DATA_W'(wq[2].data[255:248]), DATA_W'(8'h40));
        end

        // Same frame with random valid gaps shorter than the timeout.
        run_frame(8'h03, 12, 1'b0);

        // Header table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].exp_err) begin
                wq.delete();
                start_hdr(vecs[i].hdr);
                check("bad_hdr_err", DATA_W'(o_err), DATA_W'(1));
                check("bad_hdr_busy", DATA_W'(o_busy), '0);
                repeat (2) tick();
                check("bad_hdr_no_write", DATA_W'(wq.size()), '0);
            end else begin
                randomize_frame();
                run_frame(vecs[i].hdr, 3, 1'b0);
            end
            check("tbl_size_out", DATA_W'(o_size_out), DATA_W'(vecs[i].exp_size));
        end

        // Timeout: header 2, ten A bytes, then silence.
        randomize_frame();
        wq.delete();
        start_hdr(8'h02);
        for (int k = 0; k < 10; k++) send_byte(fa[k], 0);
        repeat (TIMEOUT - 1) tick();
        check("to_err_early", DATA_W'(o_err), '0);
        check("to_busy_early", DATA_W'(o_busy), DATA_W'(1));
        tick();
        check("to_err", DATA_W'(o_err), DATA_W'(1));
        check("to_busy", DATA_W'(o_busy), '0);
        repeat (3) tick();
        check("to_n_writes", DATA_W'(wq.size()), DATA_W'(1));
        if (wq.size() >= 1) check("to_addr0", DATA_W'(wq[0].addr), '0);

        // Reset after 20 B bytes.
        randomize_frame();
        wq.delete();
        start_hdr(8'h04);
        for (int k = 0; k < 32; k++) send_byte(fa[k], 0);
        for (int k = 0; k < 20; k++) send_byte(fb[k], 0);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", DATA_W'(o_busy), '0);
        check("mid_rst_ready", DATA_W'(o_s_ready), '0);
        check("mid_rst_we", DATA_W'(o_ram_we), '0);
        check("mid_rst_wdata", o_ram_wdata, '0);
        check("mid_rst_size", DATA_W'(o_size_out), '0);
        rst = 1'b0;
        repeat (4) tick();
        check("mid_rst_n_writes", DATA_W'(wq.size()), DATA_W'(2));
        for (int k = 0; k < 32; k++) begin
            fa[k] = 8'(k + 1);
            fb[k] = 8'(k + 33);
        end
        run_frame(8'h03, 0, 1'b0);

        // Start pulsed while collecting A is ignored.
        randomize_frame();
        run_frame(8'h05, 2, 1'b1);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            randomize_frame();
            run_frame(8'($urandom_range(5, 2)), 12, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit reached");
    end

endmodule
